// File: rtl/ysyx_22040895_opsel_pkg.sv
// ysyx_22040895_opsel_pkg: operand-select encodings and default widths.
// Rev 1.0
`default_nettype none

package ysyx_22040895_opsel_pkg;

   localparam int XLEN_DEFAULT    = 64;
   localparam int RADDR_W_DEFAULT = 5;

   localparam logic [1:0] OP1_RS1  = 2'd0;
   localparam logic [1:0] OP1_PC   = 2'd1;
   localparam logic [1:0] OP1_ZERO = 2'd2;

   localparam logic [1:0] OP2_RS2  = 2'd0;
   localparam logic [1:0] OP2_IMM  = 2'd1;
   localparam logic [1:0] OP2_FOUR = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040895_fwd_mux.sv
// ysyx_22040895_fwd_mux: per-source priority forwarding search and hazard flag.
// Rev 1.0 -- behaviour selected by YSYX_22040895_FWD_EN.
`default_nettype none

module ysyx_22040895_fwd_mux
   import ysyx_22040895_opsel_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int RADDR_W   = RADDR_W_DEFAULT,
   parameter int FWD_PORTS = 2
) (
   input  logic [RADDR_W-1:0]           addr,
   input  logic                         used,
   input  logic [XLEN-1:0]              rdata,
   input  logic [FWD_PORTS-1:0]         fwd_valid,
   input  logic [FWD_PORTS*RADDR_W-1:0] fwd_rd,
   input  logic [FWD_PORTS*XLEN-1:0]    fwd_data,
   input  logic [FWD_PORTS-1:0]         fwd_is_load,
   output logic [XLEN-1:0]              value,
   output logic                         hazard
);

   logic [FWD_PORTS-1:0] match;
   logic                 nonzero;

   assign nonzero = |addr;

   genvar g;
   generate
      for (g = 0; g < FWD_PORTS; g++) begin : g_match
         assign match[g] = fwd_valid[g] && (fwd_rd[g*RADDR_W +: RADDR_W] == addr);
      end
   endgenerate

`ifdef YSYX_22040895_FWD_EN
   logic            hit;
   logic            hit_load;
   logic [XLEN-1:0] hit_data;

   // Scan oldest to youngest so the lowest-index match is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_load = 1'b0;
      hit_data = rdata;
      for (int i = FWD_PORTS - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit      = 1'b1;
            hit_load = fwd_is_load[i];
            hit_data = fwd_data[i*XLEN +: XLEN];
         end
      end
   end

   assign value  = nonzero ? hit_data : '0;
   assign hazard = used && nonzero && hit && hit_load;
`else
   logic unused_fwd;

   // Without a bypass network any pending write to a used source must drain first.
   assign value      = nonzero ? rdata : '0;
   assign hazard     = used && nonzero && (|match);
   assign unused_fwd = ^{fwd_data, fwd_is_load};
`endif

endmodule

`default_nettype wire

// File: rtl/ysyx_22040895_opsel_stage.sv
// ysyx_22040895_opsel_stage: ID/EX operand select, hazard resolution and output register.
// Rev 1.0 -- define YSYX_22040895_FWD_EN to enable data forwarding.
`default_nettype none

module ysyx_22040895_opsel_stage
   import ysyx_22040895_opsel_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int RADDR_W   = RADDR_W_DEFAULT,
   parameter int FWD_PORTS = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   op1_sel,
   input  logic [1:0]                   op2_sel,
   input  logic [RADDR_W-1:0]           rs1_addr,
   input  logic [RADDR_W-1:0]           rs2_addr,
   input  logic                         rs1_used,
   input  logic                         rs2_used,
   input  logic [XLEN-1:0]              rdata1,
   input  logic [XLEN-1:0]              rdata2,
   input  logic [XLEN-1:0]              pc,
   input  logic [XLEN-1:0]              simm,
   input  logic [FWD_PORTS-1:0]         fwd_valid,
   input  logic [FWD_PORTS*RADDR_W-1:0] fwd_rd,
   input  logic [FWD_PORTS*XLEN-1:0]    fwd_data,
   input  logic [FWD_PORTS-1:0]         fwd_is_load,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [XLEN-1:0]              opnum1,
   output logic [XLEN-1:0]              opnum2,
   output logic [XLEN-1:0]              store_data
);

   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            haz1;
   logic            haz2;
   logic            stall;
   logic            transfer;
   logic [XLEN-1:0] op1_next;
   logic [XLEN-1:0] op2_next;

   ysyx_22040895_fwd_mux #(
      .XLEN      (XLEN),
      .RADDR_W   (RADDR_W),
      .FWD_PORTS (FWD_PORTS)
   ) u_fwd_rs1 (
      .addr        (rs1_addr),
      .used        (rs1_used),
      .rdata       (rdata1),
      .fwd_valid   (fwd_valid),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .fwd_is_load (fwd_is_load),
      .value       (src1),
      .hazard      (haz1)
   );

   ysyx_22040895_fwd_mux #(
      .XLEN      (XLEN),
      .RADDR_W   (RADDR_W),
      .FWD_PORTS (FWD_PORTS)
   ) u_fwd_rs2 (
      .addr        (rs2_addr),
      .used        (rs2_used),
      .rdata       (rdata2),
      .fwd_valid   (fwd_valid),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .fwd_is_load (fwd_is_load),
      .value       (src2),
      .hazard      (haz2)
   );

   // Built only from hazard, flush and output state so it never loops back through in_valid.
   assign stall    = haz1 || haz2;
   assign in_ready = !stall && !flush && (!out_valid || out_ready);
   assign transfer = in_valid && in_ready;

   always_comb begin
      op1_next = '0;
      case (op1_sel)
         OP1_RS1:  op1_next = src1;
         OP1_PC:   op1_next = pc;
         OP1_ZERO: op1_next = '0;
         default:  op1_next = '0;
      endcase
   end

   always_comb begin
      op2_next = '0;
      case (op2_sel)
         OP2_RS2:  op2_next = src2;
         OP2_IMM:  op2_next = simm;
         OP2_FOUR: op2_next = XLEN'(4);
         default:  op2_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         opnum1     <= '0;
         opnum2     <= '0;
         store_data <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (transfer) begin
         out_valid  <= 1'b1;
         opnum1     <= op1_next;
         opnum2     <= op2_next;
         store_data <= src2;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040895_opsel_stage.sv
// tb_ysyx_22040895_opsel_stage: vector table, corner sequences and randomized model check.
// Rev 1.0 -- expectations follow YSYX_22040895_FWD_EN when it is defined.
`default_nettype none

module tb_ysyx_22040895_opsel_stage;

   localparam int XLEN      = 64;
   localparam int RADDR_W   = 5;
   localparam int FWD_PORTS = 2;

   localparam bit FWD_EN =
`ifdef YSYX_22040895_FWD_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, in_valid, in_ready, flush, out_valid, out_ready, rs1_used, rs2_used;
   logic [1:0] op1_sel, op2_sel;
   logic [RADDR_W-1:0] rs1_addr, rs2_addr;
   logic [XLEN-1:0] rdata1, rdata2, pc, simm, opnum1, opnum2, store_data;

   logic            fv   [FWD_PORTS];
   logic [4:0]      frd  [FWD_PORTS];
   logic [63:0]     fdat [FWD_PORTS];
   logic            fld  [FWD_PORTS];
   logic [FWD_PORTS-1:0]         fwd_valid, fwd_is_load;
   logic [FWD_PORTS*RADDR_W-1:0] fwd_rd;
   logic [FWD_PORTS*XLEN-1:0]    fwd_data;

   assign fwd_valid   = {fv[1], fv[0]};
   assign fwd_is_load = {fld[1], fld[0]};
   assign fwd_rd      = {frd[1], frd[0]};
   assign fwd_data    = {fdat[1], fdat[0]};

   ysyx_22040895_opsel_stage #(
      .XLEN(XLEN), .RADDR_W(RADDR_W), .FWD_PORTS(FWD_PORTS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1_sel(op1_sel), .op2_sel(op2_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .rdata1(rdata1), .rdata2(rdata2),
      .pc(pc), .simm(simm), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .fwd_is_load(fwd_is_load), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .opnum1(opnum1), .opnum2(opnum2), .store_data(store_data)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference state of the output register.
   logic        ev;
   logic [63:0] eo1, eo2, esd;
   logic        last_ready;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Source value and stall, straight from the resolution rules.
   function automatic void ref_src(input logic [4:0] a, input logic u, input logic [63:0] rd,
                                   output logic [63:0] v, output logic h);
      bit found;
      found = 1'b0;
      v = 64'd0;
      h = 1'b0;
      if (a != 5'd0) begin
         v = rd;
         for (int i = 0; i < FWD_PORTS; i++) begin
            if (!found && fv[i] && frd[i] == a) begin
               found = 1'b1;
               if (FWD_EN) begin
                  v = fdat[i];
                  h = u && fld[i];
               end else begin
                  h = u;
               end
            end
         end
      end
   endfunction

   task automatic cycle();
      logic [63:0] v1, v2, o1, o2;
      logic h1, h2, rdy, xfer;
      #3;
      ref_src(rs1_addr, rs1_used, rdata1, v1, h1);
      ref_src(rs2_addr, rs2_used, rdata2, v2, h2);
      rdy = !(h1 || h2) && !flush && (!ev || out_ready);
      last_ready = in_ready;
      chk("model in_ready", in_ready, rdy);
      xfer = in_valid && rdy;
      o1 = (op1_sel == 2'd0) ? v1 : (op1_sel == 2'd1) ? pc : 64'd0;
      o2 = (op2_sel == 2'd0) ? v2 : (op2_sel == 2'd1) ? simm : (op2_sel == 2'd2) ? 64'd4 : 64'd0;
      @(posedge clk);
      if (flush) ev = 1'b0;
      else if (xfer) begin
         ev = 1'b1; eo1 = o1; eo2 = o2; esd = v2;
      end else if (out_ready) ev = 1'b0;
      #1;
      chk("model out_valid", out_valid, ev);
      chk("model opnum1", opnum1, eo1);
      chk("model opnum2", opnum2, eo2);
      chk("model store_data", store_data, esd);
   endtask

   task automatic idle();
      in_valid = 0; flush = 0; out_ready = 1; op1_sel = 0; op2_sel = 0;
      rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
      rdata1 = 0; rdata2 = 0; pc = 0; simm = 0;
      for (int i = 0; i < FWD_PORTS; i++) begin
         fv[i] = 0; frd[i] = 0; fdat[i] = 0; fld[i] = 0;
      end
   endtask

   typedef struct {
      logic [1:0]  s1, s2;
      logic [4:0]  a1, a2;
      logic        u1, u2;
      logic [63:0] r1, r2, pcv, imm;
      logic [1:0]  v;
      logic [4:0]  d0, d1;
      logic [63:0] x0, x1;
      logic [1:0]  ld;
      logic        rdy;
      logic [63:0] e1, e2, es;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{2'd0, 2'd1, 5'd1, 5'd2, 1'b1, 1'b1, 64'h10, 64'h20, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0,
                2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20};
      vt[1] = '{2'd0, 2'd2, 5'd5, 5'd6, 1'b1, 1'b1, 64'h11, 64'h66, 64'h0, 64'h0,
                2'b11, 5'd5, 5'd5, 64'hAA, 64'hBB, 2'b00, FWD_EN, 64'hAA, 64'h4, 64'h66};
      vt[2] = '{2'd0, 2'd0, 5'd0, 5'd2, 1'b1, 1'b1, 64'h123, 64'h22, 64'h0, 64'h0,
                2'b01, 5'd0, 5'd0, 64'h77, 64'h0, 2'b00, 1'b1, 64'h0, 64'h22, 64'h22};
      vt[3] = '{2'd1, 2'd1, 5'd1, 5'd7, 1'b1, 1'b1, 64'h1, 64'h70, 64'h8000_0000, 64'h1234,
                2'b10, 5'd0, 5'd7, 64'h0, 64'h55, 2'b00, FWD_EN, 64'h8000_0000, 64'h1234, 64'h55};
      vt[4] = '{2'd3, 2'd3, 5'd1, 5'd2, 1'b1, 1'b1, 64'h10, 64'h22, 64'h4, 64'h5,
                2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 1'b1, 64'h0, 64'h0, 64'h22};
      vt[5] = '{2'd0, 2'd0, 5'd3, 5'd2, 1'b1, 1'b1, 64'h33, 64'h22, 64'h0, 64'h0,
                2'b01, 5'd3, 5'd0, 64'h99, 64'h0, 2'b01, 1'b0, 64'h0, 64'h0, 64'h0};
      vt[6] = '{2'd0, 2'd2, 5'd3, 5'd0, 1'b0, 1'b1, 64'h33, 64'h22, 64'h0, 64'h0,
                2'b01, 5'd3, 5'd0, 64'h99, 64'h0, 2'b01, 1'b1, FWD_EN ? 64'h99 : 64'h33, 64'h4, 64'h0};
      vt[7] = '{2'd0, 2'd0, 5'd9, 5'd2, 1'b1, 1'b1, 64'h90, 64'h22, 64'h0, 64'h0,
                2'b11, 5'd9, 5'd9, 64'hC0, 64'hD0, 2'b10, FWD_EN, 64'hC0, 64'h22, 64'h22};
      vt[8] = '{2'd2, 2'd0, 5'd1, 5'd4, 1'b1, 1'b1, 64'h10, 64'h40, 64'h0, 64'h0,
                2'b10, 5'd0, 5'd4, 64'h0, 64'h44, 2'b00, FWD_EN, 64'h0, 64'h44, 64'h44};
      vt[9] = '{2'd0, 2'd0, 5'd13, 5'd2, 1'b1, 1'b1, 64'hD0D0, 64'h22, 64'h0, 64'h0,
                2'b01, 5'd12, 5'd0, 64'hEE, 64'h0, 2'b00, 1'b1, 64'hD0D0, 64'h22, 64'h22};

      // Reset state
      idle();
      rst_n = 0;
      ev = 0; eo1 = 0; eo2 = 0; esd = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", out_valid, 0);
      chk("reset opnum1", opnum1, 0);
      chk("reset opnum2", opnum2, 0);
      chk("reset store_data", store_data, 0);
      rst_n = 1;
      #2;
      chk("reset in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Vector table
      for (int k = 0; k < 10; k++) begin
         idle();
         in_valid = 1;
         op1_sel = vt[k].s1; op2_sel = vt[k].s2;
         rs1_addr = vt[k].a1; rs2_addr = vt[k].a2;
         rs1_used = vt[k].u1; rs2_used = vt[k].u2;
         rdata1 = vt[k].r1; rdata2 = vt[k].r2; pc = vt[k].pcv; simm = vt[k].imm;
         fv[0] = vt[k].v[0]; fv[1] = vt[k].v[1];
         frd[0] = vt[k].d0; frd[1] = vt[k].d1;
         fdat[0] = vt[k].x0; fdat[1] = vt[k].x1;
         fld[0] = vt[k].ld[0]; fld[1] = vt[k].ld[1];
         cycle();
         chk($sformatf("vec%0d in_ready", k), last_ready, vt[k].rdy);
         chk($sformatf("vec%0d out_valid", k), out_valid, vt[k].rdy);
         if (vt[k].rdy) begin
            chk($sformatf("vec%0d opnum1", k), opnum1, vt[k].e1);
            chk($sformatf("vec%0d opnum2", k), opnum2, vt[k].e2);
            chk($sformatf("vec%0d store_data", k), store_data, vt[k].es);
         end
      end

      // Load-use stall, release when the load completes, then unused-source case
      idle();
      in_valid = 1; rs1_addr = 3; rs1_used = 1; rdata1 = 64'h31;
      fv[0] = 1; frd[0] = 3; fld[0] = 1;
      cycle();
      chk("loaduse stall", last_ready, 0);
      chk("loaduse bubble", out_valid, 0);
      fld[0] = 0; fdat[0] = 64'h99;
      cycle();
      chk("loaduse release", last_ready, FWD_EN);
      if (FWD_EN) chk("loaduse opnum1", opnum1, 64'h99);
      fv[0] = 0;
      cycle();
      chk("loaduse drained", last_ready, 1);
      chk("loaduse drained opnum1", opnum1, 64'h31);
      fv[0] = 1; fld[0] = 1; rs1_used = 0;
      cycle();
      chk("unused no stall", last_ready, 1);

      // Backpressure then flush
      idle();
      in_valid = 1; op1_sel = 1; op2_sel = 1; pc = 64'hABC; simm = 64'hDEF;
      cycle();
      out_ready = 0; pc = 64'h111; simm = 64'h222;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp in_ready", last_ready, 0);
         chk("bp out_valid", out_valid, 1);
         chk("bp opnum1", opnum1, 64'hABC);
         chk("bp opnum2", opnum2, 64'hDEF);
      end
      flush = 1;
      cycle();
      chk("flush in_ready", last_ready, 0);
      chk("flush out_valid", out_valid, 0);
      out_ready = 1;
      cycle();
      chk("flush empty no xfer", out_valid, 0);
      flush = 0;
      cycle();
      chk("post flush out_valid", out_valid, 1);
      chk("post flush opnum1", opnum1, 64'h111);

      // Non-load pending write to rs2: stalls only without forwarding
      idle();
      in_valid = 1; rs2_addr = 4; rs2_used = 1; rdata2 = 64'h40;
      fv[1] = 1; frd[1] = 4; fdat[1] = 64'h44;
      cycle();
      chk("nofwd stall 1", last_ready, FWD_EN);
      if (FWD_EN) chk("fwd rs2 opnum2", opnum2, 64'h44);
      cycle();
      chk("nofwd stall 2", last_ready, FWD_EN);
      fv[1] = 0;
      cycle();
      chk("nofwd release", last_ready, 1);
      chk("nofwd opnum2", opnum2, 64'h40);

      // Reset in the middle of an accepted transfer
      idle();
      in_valid = 1; op1_sel = 1; pc = 64'h5555;
      #2 rst_n = 0;
      #1;
      ev = 0; eo1 = 0; eo2 = 0; esd = 0;
      chk("midreset out_valid", out_valid, 0);
      chk("midreset opnum1", opnum1, 0);
      @(posedge clk);
      #1;
      chk("midreset held", out_valid, 0);
      rst_n = 1;

      // Randomized run against the reference model
      for (int k = 0; k < 400; k++) begin
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         op1_sel   = 2'($urandom_range(0, 3));
         op2_sel   = 2'($urandom_range(0, 3));
         rs1_addr  = 5'($urandom_range(0, 7));
         rs2_addr  = 5'($urandom_range(0, 7));
         rs1_used  = 1'($urandom);
         rs2_used  = 1'($urandom);
         rdata1    = {$urandom, $urandom};
         rdata2    = {$urandom, $urandom};
         pc        = {$urandom, $urandom};
         simm      = {$urandom, $urandom};
         for (int i = 0; i < FWD_PORTS; i++) begin
            fv[i]   = 1'($urandom);
            frd[i]  = 5'($urandom_range(0, 7));
            fdat[i] = {$urandom, $urandom};
            fld[i]  = ($urandom_range(0, 2) == 0);
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ysyx_22040895_opsel_stage.md
# ysyx_22040895_opsel_stage

Parametrised ID/EX operand-select stage for the ysyx_22040895 core. It selects operand 1 from rs1/PC/zero and operand 2 from rs2/immediate/constant 4. It resolves RAW hazards by forwarding from up to `FWD_PORTS` younger pipeline stages, or by stalling on load-use. Results are registered behind a valid/ready handshake feeding the EXU.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `RADDR_W`, 5: register index width.
- `FWD_PORTS`, 2: forwarding sources; port 0 is youngest (EX), higher index is older (MEM, WB).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `op1_sel` in 2: 0 = rs1, 1 = pc, 2 = zero, 3 = reserved (treated as zero).
- `op2_sel` in 2: 0 = rs2, 1 = imm, 2 = const 4, 3 = reserved (treated as zero).
- `rs1_addr`, `rs2_addr` in RADDR_W: source indices.
- `rs1_used`, `rs2_used` in 1: source actually read; gates hazard checks.
- `rdata1`, `rdata2` in XLEN: register-file read data.
- `pc` in XLEN: instruction PC.
- `simm` in XLEN: sign-extended immediate.
- `fwd_valid` in FWD_PORTS: forwarding port carries a live write.
- `fwd_rd` in FWD_PORTS*RADDR_W: destination index per port.
- `fwd_data` in FWD_PORTS*XLEN: result per port.
- `fwd_is_load` in FWD_PORTS: result not yet available (load in flight).
- `flush` in 1: kill the registered instruction and refuse new input this cycle.
- `out_valid` out 1: operands valid.
- `out_ready` in 1: EXU consumes this cycle.
- `opnum1`, `opnum2` out XLEN: selected operands.
- `store_data` out XLEN: forwarded rs2 value, independent of `op2_sel`.

## Operation
- Source resolution runs per source (rs1, rs2):
  - x0 always resolves to 0 and never matches or stalls.
  - Otherwise take the lowest-index port with `fwd_valid` and `fwd_rd == addr`. If there is no match, take `rdataN`.
- Hazard (stall) is set when a used, nonzero source's highest-priority match has `fwd_is_load = 1`. A load on an older port is masked by a younger non-load match to the same rd.
- `in_ready = !stall && !flush && (!out_valid || out_ready)`.
- A transfer occurs when `in_valid && in_ready`. The output register then loads `opnum1`, `opnum2` and `store_data`, and `out_valid` goes to 1.
- `out_ready && !transfer` clears `out_valid`. This inserts a bubble when stalled.
- `flush` clears `out_valid` next edge and overrides a simultaneous transfer. Data registers may hold stale values.
- Reserved select codes produce 0; they are not an error.

## Timing
- Latency is 1 cycle from accepted input to `out_valid`.
- Throughput is 1 per cycle when there are no stalls.
- Reset: `out_valid = 0`, and `opnum1`, `opnum2`, `store_data` = 0. Reset asserted mid-transfer discards the instruction.
- Hazard evaluation is purely combinational on the current-cycle forwarding inputs. A stall releases the same cycle `fwd_is_load` drops.
- `in_ready` never depends combinationally on `in_valid`.
- While `out_valid && !out_ready`, outputs are held stable.

## Configuration
- `YSYX_22040895_FWD_EN` defined: forwarding as above.
- Not defined: no data forwarding. Any used, nonzero source matching any valid port stalls regardless of `fwd_is_load`. Sources always come from `rdataN`, and `fwd_data` is ignored.

## Structure
- Shared package/include holds:
  - `OP1_RS1`, `OP1_PC`, `OP1_ZERO`, `OP2_RS2`, `OP2_IMM`, `OP2_FOUR` encodings.
  - Default `XLEN`/`RADDR_W`.
- Sub-module `ysyx_22040895_fwd_mux` is instantiated twice (rs1, rs2).
  - Inputs: addr, used, regfile data, forwarding buses.
  - Outputs: resolved value and hazard flag.
  - It contains the priority search.

## Test plan
- Reset, then `in_valid = 1`, `op1_sel = 0`, `op2_sel = 1`, `rdata1 = 0x10`, `simm = 0xFFFF_FFFF_FFFF_FFF0`, no forwards → next cycle `out_valid = 1`, `opnum1 = 0x10`, `opnum2 = -16`.
- rs1 = 5; port 0 {rd 5, data 0xAA}; port 1 {rd 5, data 0xBB} → `opnum1 = 0xAA` (youngest wins). rs1 = 0 with port 0 rd 0 → `opnum1 = 0`.
- rs2 = 7, `op2_sel = 1`; port 1 {rd 7, data 0x55} → `opnum2 = simm`, `store_data = 0x55`.
- Load-use: port 0 {rd 3, is_load}, rs1 = 3 used → `in_ready = 0` and a bubble. The next cycle is_load drops with data 0x99 → accepted, `opnum1 = 0x99`. The same pattern with `rs1_used = 0` → no stall.
- Backpressure and flush: hold `out_ready = 0` for 3 cycles → outputs stable and `in_ready = 0`. Assert `flush` with `in_valid = 1` → `out_valid = 0` next cycle and no transfer.
- Without `YSYX_22040895_FWD_EN`: port 1 {rd 4, non-load}, rs2 = 4 → stall until `fwd_valid` drops, then `opnum2 = rdata2`.
